// File: rtl/kgp_arb_pkg.sv
// kgp_arb_pkg: shared encodings for the memory port arbiter.
// State, grant and latency bounds used by mem_port_arb.
package kgp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter for the memory wait phase.
// zero is high once the count has drained.
module mem_lat_counter #(
  parameter int W = 4
) (
  input  logic         clkf,
  input  logic         start,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clkf) begin
    if (!start) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-port memory between fetch and data ports.
// Define ARB_PERF_EN to add grant and stall counters.
module mem_port_arb
  import kgp_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clkf,
  input  logic          start,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   if_cnt,
  output logic [31:0]   dm_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int LAT =
    (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
    (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
    MEM_LAT;

  // WAIT exits on zero, so preload two less than the latency
  localparam logic [LAT_W-1:0] WAIT_LD =
    LAT_W'((LAT > 1) ? LAT - 2 : 0);

  arb_state_t    state;
  arb_state_t    state_n;
  gnt_t          gnt;
  gnt_t          last_grant;
  gnt_t          pick;
  logic          any_req;
  logic          lat_zero;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  assign any_req = if_req | dm_req;
  assign pick    =
    (if_req && (!dm_req || last_grant == GNT_DM)) ?
    GNT_IF : GNT_DM;

  mem_lat_counter #(
    .W(LAT_W)
  ) u_lat (
    .clkf (clkf),
    .start(start),
    .load (state == ISSUE),
    .init (WAIT_LD),
    .dec  (state == WAIT),
    .zero (lat_zero)
  );

  always_ff @(posedge clkf) begin
    if (!start) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = (LAT == 1) ? ACK : WAIT;
      WAIT:    if (lat_zero) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkf) begin
    if (!start) begin
      gnt        <= GNT_IF;
      last_grant <= GNT_DM;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else if (state == IDLE && any_req) begin
      gnt     <= pick;
      addr_q  <= (pick == GNT_IF) ? if_addr : dm_addr;
      we_q    <= (pick == GNT_DM) & dm_we;
      wdata_q <= (pick == GNT_DM) ? dm_wdata : '0;
    end else if (state == ACK) begin
      last_grant <= gnt;
    end
  end

  // mem_rdata is valid during ACK; ack and data appear the cycle after
  always_ff @(posedge clkf) begin
    if (!start) begin
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (state == ACK) begin
        if (gnt == GNT_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_ack <= 1'b1;
          if (!we_q) dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

`ifdef ARB_PERF_EN
  // both requesters may stall in one cycle; each adds one
  logic [1:0] stall_inc;

  assign stall_inc = {1'b0, if_req & ~if_ack}
                   + {1'b0, dm_req & ~dm_ack};

  always_ff @(posedge clkf) begin
    if (!start) begin
      if_cnt    <= '0;
      dm_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == ACK && gnt == GNT_IF) if_cnt <= if_cnt + 32'd1;
      if (state == ACK && gnt == GNT_DM) dm_cnt <= dm_cnt + 32'd1;
      stall_cnt <= stall_cnt + {30'd0, stall_inc};
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed and random checks of mem_port_arb at
// MEM_LAT=1 (u0) and MEM_LAT=4 (u1) against a transaction-level model.
module tb_mem_port_arb;

  logic clkf = 1'b0;
  always #5 clkf = ~clkf;

  logic        start[2];
  logic        if_req[2], dm_req[2], dm_we[2];
  logic [31:0] if_addr[2], dm_addr[2], dm_wdata[2], mem_rdata[2];
  logic [31:0] if_rdata[2], dm_rdata[2], mem_addr[2], mem_wdata[2];
  logic        if_ack[2], dm_ack[2], mem_en[2], mem_we[2], busy[2];
`ifdef ARB_PERF_EN
  logic [31:0] if_cnt[2], dm_cnt[2], stall_cnt[2];
`endif

  int nchk = 0;
  int nerr = 0;

  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(1)) u0 (
    .clkf(clkf), .start(start[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]),
    .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0])
`ifdef ARB_PERF_EN
    , .if_cnt(if_cnt[0]), .dm_cnt(dm_cnt[0]), .stall_cnt(stall_cnt[0])
`endif
  );

  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(4)) u1 (
    .clkf(clkf), .start(start[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]),
    .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1])
`ifdef ARB_PERF_EN
    , .if_cnt(if_cnt[1]), .dm_cnt(dm_cnt[1]), .stall_cnt(stall_cnt[1])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000) + 32'h1357;
  endfunction

  // memory: data valid only in the cycle MEM_LAT after the issue cycle
  int          mcnt[2];
  logic [31:0] maddr[2];

  always @(posedge clkf)
    for (int d = 0; d < 2; d++)
      if (mem_en[d] === 1'b1) begin
        mcnt[d]  <= lat_of(d);
        maddr[d] <= mem_addr[d];
      end else if (mcnt[d] > 0) begin
        mcnt[d] <= mcnt[d] - 1;
      end

  always_comb
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (mcnt[d] == 1) ? memfun(maddr[d]) : 32'hBAD0_0BAD;

  // model: a transaction sampled at the end of cycle s issues in s+1,
  // sees data in s+LAT+1 and is acknowledged in s+LAT+2
  int          cyc = 0;
  bit          act[2], mg[2], lastg[2], mwe[2], eifa[2], edma[2];
  int          s[2];
  logic [31:0] ma[2], mwd[2], eifr[2], edmr[2];
  logic [31:0] eifc[2], edmc[2], estl[2];

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      if (!start[d]) begin
        act[d] = 0; lastg[d] = 1; eifa[d] = 0; edma[d] = 0;
        eifr[d] = '0; edmr[d] = '0;
        eifc[d] = '0; edmc[d] = '0; estl[d] = '0;
      end else begin
        if (if_req[d] && !eifa[d]) estl[d] = estl[d] + 1;
        if (dm_req[d] && !edma[d]) estl[d] = estl[d] + 1;
        eifa[d] = 0;
        edma[d] = 0;
        if (act[d] && cyc == s[d] + lat_of(d) + 1) begin
          if (!mg[d]) begin
            eifa[d] = 1; eifr[d] = memfun(ma[d]); eifc[d] = eifc[d] + 1;
          end else begin
            edma[d] = 1; edmc[d] = edmc[d] + 1;
            if (!mwe[d]) edmr[d] = memfun(ma[d]);
          end
          lastg[d] = mg[d];
          act[d]   = 0;
        end else if (!act[d] && (if_req[d] || dm_req[d])) begin
          mg[d]  = (if_req[d] && dm_req[d]) ? !lastg[d] : dm_req[d];
          s[d]   = cyc;
          act[d] = 1;
          ma[d]  = mg[d] ? dm_addr[d] : if_addr[d];
          mwe[d] = mg[d] && dm_we[d];
          mwd[d] = dm_wdata[d];
        end
      end
    end
    cyc++;
  endtask

  always @(posedge clkf) model_tick();

  always @(negedge clkf)
    for (int d = 0; d < 2; d++) begin
      bit een;
      een = act[d] && (cyc == s[d] + 1);
      chk($sformatf("busy%0d", d), busy[d], act[d]);
      chk($sformatf("mem_en%0d", d), mem_en[d], een);
      chk($sformatf("mem_we%0d", d), mem_we[d], een && mwe[d]);
      if (een) chk($sformatf("mem_addr%0d", d), mem_addr[d], ma[d]);
      if (een && mwe[d])
        chk($sformatf("mem_wdata%0d", d), mem_wdata[d], mwd[d]);
      chk($sformatf("if_ack%0d", d), if_ack[d], eifa[d]);
      chk($sformatf("dm_ack%0d", d), dm_ack[d], edma[d]);
      chk($sformatf("if_rdata%0d", d), if_rdata[d], eifr[d]);
      chk($sformatf("dm_rdata%0d", d), dm_rdata[d], edmr[d]);
      chk($sformatf("ack_excl%0d", d), if_ack[d] & dm_ack[d], 0);
`ifdef ARB_PERF_EN
      chk($sformatf("if_cnt%0d", d), if_cnt[d], eifc[d]);
      chk($sformatf("dm_cnt%0d", d), dm_cnt[d], edmc[d]);
      chk($sformatf("stall_cnt%0d", d), stall_cnt[d], estl[d]);
`endif
    end

  task automatic drive_rand(input int d);
    if (if_req[d]) begin
      if (if_ack[d]) begin
        if ($urandom_range(1, 0) == 0) if_req[d] = 1'b0;
        else if_addr[d] = $urandom;
      end else if ($urandom_range(63, 0) == 0) begin
        if_req[d] = 1'b0;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      if_req[d]  = 1'b1;
      if_addr[d] = $urandom;
    end
    if (dm_req[d]) begin
      if (dm_ack[d]) begin
        if ($urandom_range(1, 0) == 0) dm_req[d] = 1'b0;
        else begin
          dm_we[d] = $urandom_range(1, 0) == 1;
          dm_addr[d] = $urandom; dm_wdata[d] = $urandom;
        end
      end else if ($urandom_range(63, 0) == 0) begin
        dm_req[d] = 1'b0;
      end
    end else if ($urandom_range(2, 0) == 0) begin
      dm_req[d]   = 1'b1;
      dm_we[d]    = $urandom_range(1, 0) == 1;
      dm_addr[d]  = $urandom;
      dm_wdata[d] = $urandom;
    end
  endtask

  initial begin
    int n, k, nen, nack;
    int seq[4];
    logic [31:0] prev;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; if_req[d] = 1'b1; dm_req[d] = 1'b1;
      dm_we[d] = 1'b0; if_addr[d] = 32'h10; dm_addr[d] = 32'h20;
      dm_wdata[d] = '0;
    end

    // reset held with both requests high
    repeat (5) @(negedge clkf);
    chk("rst_en", mem_en[0], 0);
    chk("rst_ack", {if_ack[0], dm_ack[0]}, 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_rd", if_rdata[0] | dm_rdata[0], 0);
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1; if_req[d] = 1'b0; dm_req[d] = 1'b0;
    end
    repeat (2) @(negedge clkf);

    // lone fetch
    if_addr[0] = 32'h40; if_req[0] = 1'b1;
    n = 0;
    do begin @(negedge clkf); n++; end while (!if_ack[0] && n < 20);
    chk("fetch_lat", n, 3);
    chk("fetch_rd", if_rdata[0], 32'hDEAD_BEEF);
    if_req[0] = 1'b0;
    @(negedge clkf);

    // conflict right after reset, both held
    start[0] = 1'b0;
    repeat (2) @(negedge clkf);
    start[0] = 1'b1; if_req[0] = 1'b1; dm_req[0] = 1'b1;
    if_addr[0] = 32'h80; dm_addr[0] = 32'h300; dm_we[0] = 1'b0;
    seq = '{9, 9, 9, 9};
    k = 0; n = 0;
    while (k < 4 && n < 60) begin
      @(negedge clkf); n++;
      if (if_ack[0]) begin seq[k] = 0; k++; end
      else if (dm_ack[0]) begin seq[k] = 1; k++; end
    end
    chk("conf_cnt", k, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("conf_seq%0d", i), seq[i], i % 2);

    // store
    if_req[0] = 1'b0;
    prev = dm_rdata[0];
    dm_we[0] = 1'b1; dm_addr[0] = 32'h100; dm_wdata[0] = 32'h1234_5678;
    n = 0; nen = 0;
    do begin
      @(negedge clkf); n++;
      if (mem_en[0]) begin
        nen++;
        chk("st_we", mem_we[0], 1);
        chk("st_addr", mem_addr[0], 32'h100);
        chk("st_data", mem_wdata[0], 32'h1234_5678);
      end
    end while (!dm_ack[0] && n < 20);
    chk("st_nen", nen, 1);
    chk("st_lat", n, 3);
    chk("st_rd", dm_rdata[0], prev);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    @(negedge clkf);

    // MEM_LAT=4: reset during WAIT aborts the fetch
    if_req[1] = 1'b1; if_addr[1] = 32'h200;
    nack = 0;
    repeat (2) begin @(negedge clkf); nack += int'(if_ack[1]); end
    chk("ab_busy_wait", busy[1], 1);
    start[1] = 1'b0; if_req[1] = 1'b0;
    repeat (3) begin @(negedge clkf); nack += int'(if_ack[1]); end
    chk("ab_noack", nack, 0);
    chk("ab_busy", busy[1], 0);
    start[1] = 1'b1; if_req[1] = 1'b1;
    n = 0;
    do begin @(negedge clkf); n++; end while (!if_ack[1] && n < 30);
    chk("ab_relat", n, 6);
    chk("ab_rd", if_rdata[1], memfun(32'h200));
    if_req[1] = 1'b0;
    @(negedge clkf);

`ifdef ARB_PERF_EN
    // ten alternating conflicting transactions
    start[0] = 1'b0;
    repeat (2) @(negedge clkf);
    start[0] = 1'b1; if_req[0] = 1'b1; dm_req[0] = 1'b1;
    dm_we[0] = 1'b0;
    k = 0; n = 0; nack = 2;
    while (k < 10 && n < 100) begin
      @(negedge clkf); n++;
      if (if_ack[0] || dm_ack[0]) k++;
      if (k == 10) begin if_req[0] = 1'b0; dm_req[0] = 1'b0; end
      nack += int'(if_req[0] && !if_ack[0]) + int'(dm_req[0] && !dm_ack[0]);
    end
    @(negedge clkf);
    chk("perf_if", if_cnt[0], 5);
    chk("perf_dm", dm_cnt[0], 5);
    chk("perf_stall", stall_cnt[0], nack);
`endif

    // random traffic with occasional resets
    repeat (3000) begin
      @(negedge clkf);
      for (int d = 0; d < 2; d++) begin
        start[d] = $urandom_range(249, 0) != 0;
        drive_rand(d);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; dm_req[d] = 1'b0; start[d] = 1'b1;
    end
    repeat (10) @(negedge clkf);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter AW, default 32, the address width.
REQ-002 SHALL have parameter DW, default 32, the data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, range 1..15: cycles from issue to mem_rdata valid.
REQ-004 SHALL have port clkf, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port start, input, 1 bit: synchronous active-low reset (start=0 holds reset).
REQ-006 SHALL have ports if_req (input, 1), if_addr (input, AW), if_rdata (output, DW) and if_ack (output, 1): the instruction-fetch requester.
REQ-007 SHALL have ports dm_req (input, 1), dm_we (input, 1), dm_addr (input, AW), dm_wdata (input, DW), dm_rdata (output, DW) and dm_ack (output, 1): the data-memory requester.
REQ-008 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW): the shared single-port memory.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE, WAIT and ACK.
REQ-011 IDLE SHALL move to ISSUE when any request is high, latching the grant (IF or DM) together with the winner's address, write enable and write data.
REQ-012 Arbitration SHALL work as follows:
- A single request wins.
- On a conflict, the requester not granted last wins (round-robin, using a last_grant flag).
REQ-013 ISSUE SHALL last exactly 1 cycle:
- mem_en=1.
- mem_addr, mem_we and mem_wdata driven from the latched values.
- mem_we=0 for an IF grant.
REQ-014 WAIT SHALL count MEM_LAT-1 cycles (0 cycles when MEM_LAT=1), then move to ACK.
REQ-015 ACK SHALL last 1 cycle:
- Assert the granted ack only.
- Present the captured mem_rdata on the granted rdata port; a write returns rdata unchanged.
- Update last_grant.
- Return to IDLE.
REQ-016 Latency from the request sampled in IDLE to ack SHALL be MEM_LAT+2 cycles.
REQ-017 Requesters SHALL hold req, address and data until ack; the block SHALL sample them only in IDLE.
REQ-018 A request that drops before ack SHALL NOT abort the transaction, and ack SHALL still pulse.
REQ-019 A req held high through its own ack SHALL be treated as a new request in the following IDLE cycle.
REQ-020 if_rdata and dm_rdata SHALL be registered and hold their last value between acks.
REQ-021 Outside ISSUE, mem_en and mem_we SHALL be 0.
REQ-022 if_ack and dm_ack SHALL never be high in the same cycle.

Reset
REQ-023 While start=0 at a clock edge, the block SHALL reset to:
- state IDLE
- mem_en=0, mem_we=0
- if_ack=0, dm_ack=0
- if_rdata=0, dm_rdata=0
- busy=0
- last_grant=DM, so fetch wins the first conflict.
REQ-024 start=0 mid-transaction SHALL abort it with no ack issued; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-025 With ARB_PERF_EN defined, the block SHALL add outputs if_cnt[31:0], dm_cnt[31:0] and stall_cnt[31:0]:
- if_cnt: completed IF grants.
- dm_cnt: completed DM grants.
- stall_cnt: cycles in which a request is high and its ack is low.
- All three are cleared by reset and wrap at 2^32.
REQ-026 Without ARB_PERF_EN, these ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-027 Package kgp_arb_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3), the grant encoding (IF=0, DM=1) and the MEM_LAT bounds.
REQ-028 The WAIT countdown SHALL be a sub-module, mem_lat_counter (load, decrement, zero flag); everything else SHALL be flat.

Verification
REQ-029 Reset: hold start=0 for 5 cycles with both requests high -> mem_en=0, no ack, busy=0.
REQ-030 Lone fetch, MEM_LAT=1, if_addr=0x40, memory returns 0xDEADBEEF -> if_ack 3 cycles after the request, with if_rdata=0xDEADBEEF.
REQ-031 Conflict: both requests high just after reset -> IF acked first, then DM; with both held, grants alternate IF, DM, IF, DM.
REQ-032 Store: dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 -> exactly one cycle with mem_en=1, mem_we=1, addr 0x100 and data 0x12345678; dm_ack follows; dm_rdata unchanged.
REQ-033 MEM_LAT=4 fetch with start pulsed low during WAIT -> no if_ack; after release, the re-request acks 6 cycles later.
REQ-034 With ARB_PERF_EN, 10 alternating conflicting transactions at MEM_LAT=1 -> if_cnt=5, dm_cnt=5, and stall_cnt equal to the sum of the measured wait cycles.
